// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO read-side arbiter.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_id,
  output logic [NUM_REQ-1:0]         pick_oh,
  output logic [$clog2(NUM_REQ)-1:0] pick_id,
  output logic                       pick_valid
);
  import fifo_ctrl_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    pick_oh    = '0;
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_id) + k) % NUM_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid   = 1'b1;
        pick_oh[idx] = 1'b1;
        pick_id      = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
// Optional macro FIFO_RD_ARB_STATS_EN adds a saturating drain_cnt output.
module fifo_rd_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [NUM_REQ-1:0]         req,
  output logic                       r_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [15:0]                drain_cnt
`endif
);

  localparam int IDW    = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX);
  localparam logic [IDW-1:0]    ID_LAST   = IDW'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      last_id_q, last_id_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                out_valid_q;
  logic [IDW-1:0]      out_id_q;
  logic                rd_c;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDW-1:0]      pick_id;
  logic                pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req),
    .last_id    (last_id_q),
    .pick_oh    (pick_oh),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    beat_d    = beat_q;
    rd_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !empty) begin
          state_d = BURST;
          gnt_d   = pick_oh;
          id_d    = pick_id;
          beat_d  = '0;
        end
      end
      BURST: begin
        rd_c = req[id_q] && !empty;
        if (rd_c) beat_d = beat_q + 1'b1;
        // Leave on the edge that registers the last allowed read, or as soon as no read happens.
        if (!rd_c || beat_d == BEAT_LAST) begin
          state_d   = IDLE;
          gnt_d     = '0;
          last_id_d = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the read so an aborted burst never pops a word nobody will see.
  assign r_en = rd_c && !rrst;

  always_ff @(posedge rclk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      last_id_q   <= ID_LAST;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      beat_q      <= beat_d;
      out_valid_q <= r_en;
      out_id_q    <= id_q;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = rdata;

`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if (r_en && drain_cnt_q != 16'hFFFF) drain_cnt_d = drain_cnt_q + 16'd1;
  end

  always_ff @(posedge rclk) begin
    if (rrst) drain_cnt_q <= '0;
    else      drain_cnt_q <= drain_cnt_d;
  end

  assign drain_cnt = drain_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter with a small FIFO model on the read port.
module tb_fifo_rd_arbiter;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       empty;
  logic [7:0] rdata = '0;
  logic [3:0] req;
  logic       r_en;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0] drain_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // FIFO model: words written by tasks, popped on r_en at the clock edge.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (r_en) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .empty     (empty),
    .rdata     (rdata),
    .req       (req),
    .r_en      (r_en),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    .drain_cnt (drain_cnt)
`endif
  );

  // Advance to the next cycle, apply inputs, let combinational outputs settle.
  task automatic apply_cycle(input logic rst_v, input logic [3:0] req_v);
    @(posedge rclk);
    #1;
    rrst = rst_v;
    req  = req_v;
    #1;
  endtask

  task automatic do_reset();
    apply_cycle(1'b1, 4'b0000);
    apply_cycle(1'b1, 4'b0000);
    wr_ptr = rd_ptr;
  endtask

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 8'(i);
      wr_ptr      = wr_ptr + 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    push_words(8'h55, 4);
    apply_cycle(1'b1, 4'b1111);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b want 0", r_en); end
  endtask

  // Full 4-beat burst to consumer 0, one idle cycle, then consumer 1.
  task automatic test_round_robin_burst();
    logic [3:0] exp_gnt [7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
    logic       exp_ren [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       exp_ov  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d;
    do_reset();
    push_words(8'h10, 12);
    for (int k = 0; k < 7; k++) begin
      apply_cycle(1'b0, 4'b1111);
      checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt c%0d: got %b want %b", k, gnt, exp_gnt[k]); end
      checks++; if (r_en !== exp_ren[k]) begin errors++; $display("FAIL rr_r_en c%0d: got %b want %b", k, r_en, exp_ren[k]); end
      checks++; if (out_valid !== exp_ov[k]) begin errors++; $display("FAIL rr_out_valid c%0d: got %b want %b", k, out_valid, exp_ov[k]); end
      if (exp_ov[k]) begin
        exp_d = 8'h10 + 8'(k - 2);
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rr_out_data c%0d: got %h want %h", k, out_data, exp_d); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rr_out_id c%0d: got %0d want 0", k, out_id); end
      end
    end
  endtask

  // Only consumer 2 asks; FIFO holds two words, so empty ends the burst.
  task automatic test_empty_exit();
    logic [3:0] exp_gnt [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       exp_ren [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_dat [6] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00};
    do_reset();
    push_words(8'hA1, 2);
    for (int k = 0; k < 6; k++) begin
      apply_cycle(1'b0, 4'b0100);
      checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL empty_gnt c%0d: got %b want %b", k, gnt, exp_gnt[k]); end
      checks++; if (r_en !== exp_ren[k]) begin errors++; $display("FAIL empty_r_en c%0d: got %b want %b", k, r_en, exp_ren[k]); end
      checks++; if (out_valid !== exp_ov[k]) begin errors++; $display("FAIL empty_out_valid c%0d: got %b want %b", k, out_valid, exp_ov[k]); end
      if (exp_ov[k]) begin
        checks++; if (out_data !== exp_dat[k]) begin errors++; $display("FAIL empty_out_data c%0d: got %h want %h", k, out_data, exp_dat[k]); end
        checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL empty_out_id c%0d: got %0d want 2", k, out_id); end
      end
    end
  endtask

  // Granted request drops after one beat; rotation then walks 2 -> 3 -> 0.
  task automatic test_req_drop();
    logic [3:0] req_v   [11] = '{4'b0010, 4'b0010, 4'b1101, 4'b1101, 4'b1101, 4'b1001,
                                 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] exp_gnt [11] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    logic       exp_ren [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    push_words(8'h30, 8);
    for (int k = 0; k < 11; k++) begin
      apply_cycle(1'b0, req_v[k]);
      checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL drop_gnt c%0d: got %b want %b", k, gnt, exp_gnt[k]); end
      checks++; if (r_en !== exp_ren[k]) begin errors++; $display("FAIL drop_r_en c%0d: got %b want %b", k, r_en, exp_ren[k]); end
      if (k == 2) begin
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin
          errors++; $display("FAIL drop_out c2: got valid=%b id=%0d want valid=1 id=1", out_valid, out_id);
        end
      end
    end
  endtask

  // Reset lands after beat 2; the third read must not happen and rotation restarts at 0.
  task automatic test_reset_mid_burst();
    logic       rst_v   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_gnt [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    logic       exp_ren [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    push_words(8'h70, 8);
    for (int k = 0; k < 6; k++) begin
      apply_cycle(rst_v[k], 4'b1111);
      checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL rstmid_gnt c%0d: got %b want %b", k, gnt, exp_gnt[k]); end
      checks++; if (r_en !== exp_ren[k]) begin errors++; $display("FAIL rstmid_r_en c%0d: got %b want %b", k, r_en, exp_ren[k]); end
      checks++; if (out_valid !== exp_ov[k]) begin errors++; $display("FAIL rstmid_out_valid c%0d: got %b want %b", k, out_valid, exp_ov[k]); end
    end
    checks++; if (rd_ptr != wr_ptr - 6) begin errors++; $display("FAIL rstmid_reads: got %0d words read want 2", 8 - (wr_ptr - rd_ptr)); end
  endtask

  task automatic test_empty_hold();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply_cycle(1'b0, 4'b1111);
      checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL hold_r_en c%0d: got %b want 0", k, r_en); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt c%0d: got %b want 0000", k, gnt); end
    end
  endtask

`ifdef FIFO_RD_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (drain_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d want 0", drain_cnt); end
    push_words(8'h00, 20);
    for (int k = 0; k < 40; k++) apply_cycle(1'b0, 4'b1111);
    checks++; if (drain_cnt !== 16'd20) begin errors++; $display("FAIL stats_count: got %0d want 20", drain_cnt); end
  endtask
`endif

  initial begin
    rrst = 1'b1;
    req  = 4'b0000;
    test_reset();
    test_round_robin_burst();
    test_empty_exit();
    test_req_drop();
    test_reset_mid_burst();
    test_empty_hold();
`ifdef FIFO_RD_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of read-side consumers sharing one FIFO read port (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, FIFO read data width.
REQ-003 Parameter BURST_MAX, default 4, maximum words drained per grant (1..16).
REQ-004 rclk  input  1  read-domain clock; all logic on posedge rclk.
REQ-005 rrst  input  1  synchronous, active-high reset.
REQ-006 empty  input  1  FIFO empty flag, rclk domain.
REQ-007 rdata  input  DATA_WIDTH  FIFO read data, valid one rclk after the r_en that fetched it.
REQ-008 req  input  NUM_REQ  per-consumer read request, level-sensitive.
REQ-009 r_en  output  1  FIFO read enable, combinational from state, req and empty.
REQ-010 gnt  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-011 out_valid  output  1  registered, high the cycle rdata belongs to out_id.
REQ-012 out_data  output  DATA_WIDTH  rdata passed through, qualified by out_valid.
REQ-013 out_id  output  clog2(NUM_REQ)  index of consumer owning out_data.

Function
REQ-014 FSM SHALL have two states: IDLE, BURST.
REQ-015 IDLE: if |req and !empty, pick first set req[i] scanning from last_id+1 modulo NUM_REQ, set gnt[i], beat count 0, go BURST next cycle; otherwise stay.
REQ-016 IDLE: r_en SHALL be 0.
REQ-017 BURST: r_en SHALL equal req[id] & !empty; each r_en=1 cycle increments beat count by 1.
REQ-018 BURST exits to IDLE (gnt cleared next cycle, last_id <= id) when beat count reaches BURST_MAX, or req[id]=0, or empty=1.
REQ-019 Exit on the BURST_MAX-th read SHALL take effect the same edge that registers that read; r_en SHALL never exceed BURST_MAX pulses per grant.
REQ-020 One IDLE cycle SHALL separate consecutive grants (grant gap = 1 cycle).
REQ-021 out_valid SHALL be r_en delayed by one cycle; out_id SHALL be id delayed one cycle; out_data = rdata.
REQ-022 r_en SHALL never be 1 while empty=1 (no underflow read).
REQ-023 Requests from non-granted consumers during BURST SHALL be ignored until IDLE.
REQ-024 Beat counter width clog2(BURST_MAX+1); no wrap permitted.

Reset
REQ-025 rrst=1 at an edge: state IDLE, gnt=0, out_valid=0, out_id=0, beat count 0, last_id=NUM_REQ-1 (consumer 0 first).
REQ-026 r_en SHALL be 0 in any cycle rrst=1, including mid-BURST; an in-flight read's out_valid SHALL be suppressed.

Configuration
REQ-027 Macro FIFO_RD_ARB_STATS_EN: when defined, add output drain_cnt [15:0], incremented per r_en, saturating at 16'hFFFF, cleared by rrst.
REQ-028 Without FIFO_RD_ARB_STATS_EN: no drain_cnt port or logic; all other behaviour identical.

Structure
REQ-029 Package fifo_ctrl_pkg SHALL hold the FSM state typedef (IDLE, BURST) and default BURST_MAX constant.
REQ-030 Sub-module rr_pick SHALL be purely combinational: req vector + last_id -> one-hot pick + index.

Verification
REQ-031 rrst high 2 cycles, req=4'b1111, empty=0 -> first gnt=4'b0001, 4 r_en pulses, then gnt=4'b0010 after 1 idle cycle.
REQ-032 req=4'b0100, FIFO holds 2 words -> 2 r_en, empty rises, exit to IDLE, out_valid 2 cycles with out_id=2, data in FIFO order.
REQ-033 Granted req[1] drops after 1 beat -> r_en falls same cycle, gnt clears next edge, next grant goes to req 2/3/0 per round robin.
REQ-034 rrst asserted mid-BURST after beat 2 -> r_en=0 that cycle, gnt=0, out_valid=0 next edge, next grant starts at consumer 0.
REQ-035 empty=1 with req=4'b1111 for 10 cycles -> r_en never asserts, gnt stays 0.
REQ-036 With FIFO_RD_ARB_STATS_EN, 20 reads -> drain_cnt=20; preset near 16'hFFFF -> saturates, no wrap.
